// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised sequence detector family.
// Upper bound on PAT_W supported by len_mask is MAX_PAT_W.
package seq_det_pkg;

  localparam int MAX_PAT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mask with the low 'len' bits set; callers slice it down to their own width.
  function automatic logic [MAX_PAT_W-1:0] len_mask(input int unsigned len);
    logic [63:0] tmp;
    if (len >= MAX_PAT_W) begin
      return '1;
    end
    tmp = (64'd1 << len) - 64'd1;
    return tmp[MAX_PAT_W-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector: Mealy match, registered match and
// saturating match count. One bit per clock, no back-pressure.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             x_in,
  input  logic             in_valid,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             cfg_err
);

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist, hist_nx;
  logic [LEN_W-1:0] fill, fill_nx;

  logic                 cfg_legal;
  logic [MAX_PAT_W-1:0] full_mask;
  logic [PAT_W-1:0]     mask;
  logic [PAT_W-1:0]     cand;
  logic                 enough_bits;
  logic                 hit;
  logic                 cnt_clr;

  assign cfg_legal   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign full_mask   = len_mask(32'(len_q));
  assign mask        = full_mask[PAT_W-1:0];
  assign cand        = {hist, x_in};
  assign enough_bits = (fill + LEN_W'(1)) >= len_q;

  // A load in the same cycle as a valid bit discards the bit, so it can never match.
  assign hit = (state == RUN) && in_valid && !cfg_load && enough_bits &&
               (((cand ^ pat_q) & mask) == '0);

  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    fill_nx  = fill;
    cnt_clr  = 1'b0;
    out      = hit;
    busy     = (state == RUN);
    if (cfg_load) begin
      state_nx = cfg_legal ? RUN : IDLE;
      hist_nx  = '0;
      fill_nx  = '0;
      cnt_clr  = cfg_legal;
    end else if ((state == RUN) && in_valid) begin
      hist_nx = cand[PAT_W-2:0];
      fill_nx = (fill == LEN_W'(PAT_W - 1)) ? fill : fill + LEN_W'(1);
      // Non-overlapping mode restarts the window; stale hist bits are masked by fill.
      if (hit && !ovl_q) begin
        fill_nx = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hist    <= '0;
      fill    <= '0;
      out_q   <= 1'b0;
      cfg_err <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state <= state_nx;
      hist  <= hist_nx;
      fill  <= fill_nx;
      out_q <= hit;
      if (cfg_load) begin
        cfg_err <= !cfg_legal;
        if (cfg_legal) begin
          pat_q <= cfg_pat;
          len_q <= cfg_len;
          ovl_q <= cfg_overlap;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (hit),
    .count (match_cnt)
  );

endmodule
